// File: rtl/ltsm_mbinit_pkg.sv
// Shared definitions for the MBINIT substate sequencers.
// Holds the sideband message ids used by MBINIT.PARAM, the PARAM FSM state
// encoding, the parameter payload field layout and a rate helper.
package ltsm_mbinit_pkg;

    localparam logic [3:0] MSG_PARAM_REQ  = 4'h1;
    localparam logic [3:0] MSG_PARAM_RESP = 4'h2;

    // Payload layout: {rate[2:0], clkmode, phase}
    localparam int unsigned PL_W        = 5;
    localparam int unsigned PL_RATE_MSB = 4;
    localparam int unsigned PL_RATE_LSB = 2;
    localparam int unsigned PL_CLKMODE  = 1;
    localparam int unsigned PL_PHASE    = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_REQ  = 3'd1,
        ST_WAIT_REQ  = 3'd2,
        ST_CHECK     = 3'd3,
        ST_SEND_RESP = 3'd4,
        ST_WAIT_RESP = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } param_state_e;

    // The agreed rate is the lower of the two advertised maxima.
    function automatic logic [2:0] min_rate(input logic [2:0] a, input logic [2:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/mbinit_timeout_cnt.sv
// Substate timeout counter, reusable by any MBINIT substate.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_clear     synchronous clear to zero (dominates enable)
//   i_enable    count one per cycle while high
//   o_expired   high in the cycle whose increment reaches LIMIT (and while
//               saturated at LIMIT), qualified by i_enable
module mbinit_timeout_cnt #(
    parameter int unsigned LIMIT = 8000000,
    parameter int unsigned W     = 23
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);
    localparam logic [W-1:0] LAST_V  = W'(LIMIT - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != LIMIT_V)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    // Flag one cycle early so the owning FSM lands in its error state on the
    // same edge that the count reaches LIMIT.
    assign o_expired = i_enable && !i_clear && (count_q >= LAST_V);

endmodule

// File: rtl/mbinit_param_ctrl.sv
// MBINIT.PARAM substate sequencer.
// Sends the local parameter request, captures the partner request, drives the
// external parameter checker, sends the local response, waits for the partner
// response and reports done/error (including the substate timeout).
// Ports:
//   CLK, rst_n                       clock, async active-low reset
//   i_Enable                         substate active; low aborts to IDLE
//   i_TX_MaxDataRate/ClockMode/PhaseClock  local parameters
//   o_TX_valid/msg_id/data, i_TX_ack  sideband transmit handshake
//   i_RX_valid/msg_id/data           sideband receive (1-cycle pulse)
//   o_Enable_Checker, o_RX_*         checker drive (latched partner values)
//   i_Finish_Checker, i_Successful_Param  checker result
//   o_Final_MaxDataRate, o_Done, o_Error  result to MBINIT top FSM
module mbinit_param_ctrl
    import ltsm_mbinit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 8000000,
    parameter int unsigned TMR_W          = 23
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        i_Enable,
    input  logic [2:0]  i_TX_MaxDataRate,
    input  logic        i_TX_ClockMode,
    input  logic        i_TX_PhaseClock,
    output logic        o_TX_valid,
    output logic [3:0]  o_TX_msg_id,
    output logic [4:0]  o_TX_data,
    input  logic        i_TX_ack,
    input  logic        i_RX_valid,
    input  logic [3:0]  i_RX_msg_id,
    input  logic [4:0]  i_RX_data,
    output logic        o_Enable_Checker,
    output logic [2:0]  o_RX_MaxDataRate,
    output logic        o_RX_ClockMode,
    output logic        o_RX_PhaseClock,
    input  logic        i_Finish_Checker,
    input  logic        i_Successful_Param,
    output logic [2:0]  o_Final_MaxDataRate,
    output logic        o_Done,
    output logic        o_Error
);

    param_state_e    state_q, state_d;
    logic [PL_W-1:0] local_q, local_d;
    logic [PL_W-1:0] rx_q, rx_d;
    logic [2:0]      final_q, final_d;
    logic            req_rcvd_q, req_rcvd_d;
    logic            resp_rcvd_q, resp_rcvd_d;
    logic            tmr_clear, tmr_en, tmr_expired;
    logic            idle_or_abort;

    assign idle_or_abort = !i_Enable || (state_q == ST_IDLE);
    assign tmr_clear     = idle_or_abort;
    assign tmr_en        = (state_q == ST_SEND_REQ) || (state_q == ST_WAIT_REQ) ||
                           (state_q == ST_CHECK)    || (state_q == ST_SEND_RESP) ||
                           (state_q == ST_WAIT_RESP);

    mbinit_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TMR_W)
    ) u_timeout (
        .clk       (CLK),
        .rst_n     (rst_n),
        .i_clear   (tmr_clear),
        .i_enable  (tmr_en),
        .o_expired (tmr_expired)
    );

    // State register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort first, then timeout over any normal transition
    always_comb begin
        state_d = state_q;
        if (!i_Enable) begin
            state_d = ST_IDLE;
        end else if (tmr_expired) begin
            state_d = ST_ERROR;
        end else begin
            unique case (state_q)
                ST_IDLE:      state_d = ST_SEND_REQ;
                ST_SEND_REQ:  if (i_TX_ack) state_d = ST_WAIT_REQ;
                ST_WAIT_REQ:  if (req_rcvd_q) state_d = ST_CHECK;
                ST_CHECK:     if (i_Finish_Checker)
                                  state_d = i_Successful_Param ? ST_SEND_RESP : ST_ERROR;
                ST_SEND_RESP: if (i_TX_ack) state_d = ST_WAIT_RESP;
                ST_WAIT_RESP: if (resp_rcvd_q) state_d = ST_DONE;
                ST_DONE:      state_d = ST_DONE;
                ST_ERROR:     state_d = ST_ERROR;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: local parameter snapshot, RX capture flags, agreed rate
    always_comb begin
        local_d     = local_q;
        rx_d        = rx_q;
        final_d     = final_q;
        req_rcvd_d  = req_rcvd_q;
        resp_rcvd_d = resp_rcvd_q;
        if (idle_or_abort) begin
            rx_d        = '0;
            final_d     = '0;
            req_rcvd_d  = 1'b0;
            resp_rcvd_d = 1'b0;
            // Snapshot local params on entry so REQ payload stays stable
            local_d     = i_Enable ? {i_TX_MaxDataRate, i_TX_ClockMode, i_TX_PhaseClock} : '0;
        end else begin
            if (i_RX_valid && (i_RX_msg_id == MSG_PARAM_REQ)) begin
                req_rcvd_d = 1'b1;
                if ((state_q == ST_SEND_REQ) || (state_q == ST_WAIT_REQ)) rx_d = i_RX_data;
            end
            if (i_RX_valid && (i_RX_msg_id == MSG_PARAM_RESP)) resp_rcvd_d = 1'b1;
            if ((state_q == ST_CHECK) && i_Finish_Checker && i_Successful_Param && !tmr_expired)
                final_d = min_rate(local_q[PL_RATE_MSB:PL_RATE_LSB], rx_q[PL_RATE_MSB:PL_RATE_LSB]);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            local_q     <= '0;
            rx_q        <= '0;
            final_q     <= '0;
            req_rcvd_q  <= 1'b0;
            resp_rcvd_q <= 1'b0;
        end else begin
            local_q     <= local_d;
            rx_q        <= rx_d;
            final_q     <= final_d;
            req_rcvd_q  <= req_rcvd_d;
            resp_rcvd_q <= resp_rcvd_d;
        end
    end

    // Output logic
    always_comb begin
        o_TX_valid       = 1'b0;
        o_TX_msg_id      = '0;
        o_TX_data        = '0;
        o_Enable_Checker = 1'b0;
        o_Done           = 1'b0;
        o_Error          = 1'b0;
        unique case (state_q)
            ST_SEND_REQ: begin
                o_TX_valid  = 1'b1;
                o_TX_msg_id = MSG_PARAM_REQ;
                o_TX_data   = local_q;
            end
            ST_SEND_RESP: begin
                o_TX_valid  = 1'b1;
                o_TX_msg_id = MSG_PARAM_RESP;
                o_TX_data   = {final_q, local_q[PL_CLKMODE], local_q[PL_PHASE]};
            end
            ST_CHECK: o_Enable_Checker = 1'b1;
            ST_DONE:  o_Done           = 1'b1;
            ST_ERROR: o_Error          = 1'b1;
            default: ;
        endcase
    end

    assign o_RX_MaxDataRate    = rx_q[PL_RATE_MSB:PL_RATE_LSB];
    assign o_RX_ClockMode      = rx_q[PL_CLKMODE];
    assign o_RX_PhaseClock     = rx_q[PL_PHASE];
    assign o_Final_MaxDataRate = final_q;

endmodule
